// File: rtl/seq_alu_param_if.sv
// Handshake and data bundle for seq_alu_param.
// The issuer uses the master side. The ALU uses the slave side.
interface seq_alu_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [OP_WIDTH-1:0]   ALUOperation;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] ALUResult;
  logic                  Zero;
  logic                  Carry;
  logic                  Overflow;

  modport master (
    output in_valid, ALUOperation, A, B,
    input  in_ready, out_valid, ALUResult, Zero, Carry, Overflow
  );

  modport slave (
    input  in_valid, ALUOperation, A, B,
    output in_ready, out_valid, ALUResult, Zero, Carry, Overflow
  );
endinterface

// File: rtl/seq_alu_param.sv
// Registered ALU with a valid/ready handshake.
// Logic, add, sub and shift ops complete one cycle after accept.
// MUL and MULTPLUS use an iterative shift-add multiplier and hold off the
// issuer through in_ready until the product is ready.
module seq_alu_param #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic clk,
  input  logic reset,
  seq_alu_param_if.slave bus
);
  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  localparam logic [OP_WIDTH-1:0] OP_AND      = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_OR       = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_NOR      = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_ADD      = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_SUB      = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_INC      = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_MULTPLUS = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_MUL      = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OP_SLL      = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] OP_SRL      = OP_WIDTH'(9);

  logic [0:0]            r_state;
  logic [DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0] r_mplier;
  logic [DATA_WIDTH-1:0] r_prod;
  logic [SHAMT_W-1:0]    r_cnt;
  logic                  r_plus1;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_zero;
  logic                  r_carry;
  logic                  r_ovf;
  logic                  r_out_valid;
  logic                  r_in_ready;

  logic                  w_accept;
  logic                  w_is_mul;
  logic [SHAMT_W-1:0]    w_shamt;
  logic [DATA_WIDTH:0]   w_sum_ext;
  logic [DATA_WIDTH:0]   w_diff_ext;
  logic [DATA_WIDTH:0]   w_inc_ext;
  logic [DATA_WIDTH-1:0] w_res;
  logic                  w_carry;
  logic                  w_ovf;
  logic [DATA_WIDTH-1:0] w_step_prod;
  logic [DATA_WIDTH-1:0] w_mul_final;

  assign w_accept    = bus.in_valid & r_in_ready;
  assign w_is_mul    = (bus.ALUOperation == OP_MUL) || (bus.ALUOperation == OP_MULTPLUS);
  assign w_shamt     = bus.B[SHAMT_W-1:0];
  assign w_sum_ext   = {1'b0, bus.A} + {1'b0, bus.B};
  assign w_diff_ext  = {1'b0, bus.A} - {1'b0, bus.B};
  assign w_inc_ext   = {1'b0, bus.B} + {{DATA_WIDTH{1'b0}}, 1'b1};
  assign w_step_prod = r_prod + (r_mplier[0] ? r_mcand : {DATA_WIDTH{1'b0}});
  assign w_mul_final = w_step_prod + {{(DATA_WIDTH-1){1'b0}}, r_plus1};

  // Single-cycle datapath: result and flags for the op currently presented.
  always_comb begin
    w_res   = {DATA_WIDTH{1'b0}};
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (bus.ALUOperation)
      OP_AND: w_res = bus.A & bus.B;
      OP_OR:  w_res = bus.A | bus.B;
      OP_NOR: w_res = ~(bus.A | bus.B);
      OP_ADD: begin
        w_res   = w_sum_ext[DATA_WIDTH-1:0];
        w_carry = w_sum_ext[DATA_WIDTH];
        // Overflow: both operands share a sign and the sum sign differs from it.
        w_ovf   = (bus.A[DATA_WIDTH-1] == bus.B[DATA_WIDTH-1]) &&
                  (w_sum_ext[DATA_WIDTH-1] != bus.A[DATA_WIDTH-1]);
      end
      OP_SUB: begin
        w_res   = w_diff_ext[DATA_WIDTH-1:0];
        w_carry = w_diff_ext[DATA_WIDTH];
        // Overflow: operand signs differ and the difference sign differs from A.
        w_ovf   = (bus.A[DATA_WIDTH-1] != bus.B[DATA_WIDTH-1]) &&
                  (w_diff_ext[DATA_WIDTH-1] != bus.A[DATA_WIDTH-1]);
      end
      OP_INC: begin
        w_res   = w_inc_ext[DATA_WIDTH-1:0];
        w_carry = w_inc_ext[DATA_WIDTH];
      end
      OP_SLL: w_res = bus.A << w_shamt;
      OP_SRL: w_res = bus.A >> w_shamt;
      default: w_res = {DATA_WIDTH{1'b0}};
    endcase
  end

  // Control FSM, multiplier iteration and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_mcand     <= {DATA_WIDTH{1'b0}};
      r_mplier    <= {DATA_WIDTH{1'b0}};
      r_prod      <= {DATA_WIDTH{1'b0}};
      r_cnt       <= {SHAMT_W{1'b0}};
      r_plus1     <= 1'b0;
      r_result    <= {DATA_WIDTH{1'b0}};
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              // The accept edge already performs the step for bit 0 of B.
              // That leaves DATA_WIDTH-1 steps for the MUL state.
              r_prod     <= bus.B[0] ? bus.A : {DATA_WIDTH{1'b0}};
              r_mcand    <= bus.A << 1;
              r_mplier   <= bus.B >> 1;
              r_cnt      <= SHAMT_W'(DATA_WIDTH - 1);
              r_plus1    <= (bus.ALUOperation == OP_MULTPLUS);
              r_state    <= ST_MUL;
              r_in_ready <= 1'b0;
            end else begin
              r_result    <= w_res;
              r_zero      <= (w_res == {DATA_WIDTH{1'b0}});
              r_carry     <= w_carry;
              r_ovf       <= w_ovf;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          r_prod   <= w_step_prod;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - SHAMT_W'(1);
          if (r_cnt == SHAMT_W'(1)) begin
            r_result    <= w_mul_final;
            r_zero      <= (w_mul_final == {DATA_WIDTH{1'b0}});
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.ALUResult = r_result;
  assign bus.Zero      = r_zero;
  assign bus.Carry     = r_carry;
  assign bus.Overflow  = r_ovf;
endmodule

// File: tb/tb_seq_alu_param.sv
// Self-checking bench for seq_alu_param.
// It uses directed scenarios and a randomized run against an arithmetic reference model.
module tb_seq_alu_param;
  localparam int DW = 32;
  localparam int OW = 4;
  localparam longint MAXU = (longint'(1) << DW) - 1;
  localparam longint MAXS = (longint'(1) << (DW - 1)) - 1;
  localparam longint MINS = -(longint'(1) << (DW - 1));

  typedef struct packed {
    logic [DW-1:0] r;
    logic          z;
    logic          c;
    logic          o;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_alu_param_if #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) bus ();
  seq_alu_param #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Reference model: computes the result and flags with plain wide integer arithmetic.
  function automatic exp_t model(int unsigned op, logic [DW-1:0] a, logic [DW-1:0] b);
    exp_t e;
    longint ua, ub, sa, sb, t;
    logic [63:0] p;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e = '0;
    case (op)
      0: e.r = a & b;
      1: e.r = a | b;
      2: e.r = ~(a | b);
      3: begin
        t = ua + ub; e.r = DW'(t); e.c = (t > MAXU);
        t = sa + sb; e.o = (t > MAXS) || (t < MINS);
      end
      4: begin
        e.r = DW'(ua - ub); e.c = (ua < ub);
        t = sa - sb; e.o = (t > MAXS) || (t < MINS);
      end
      5: begin t = ub + 1; e.r = DW'(t); e.c = (t > MAXU); end
      6: begin p = 64'(ua) * 64'(ub) + 64'd1; e.r = DW'(p); end
      7: begin p = 64'(ua) * 64'(ub); e.r = DW'(p); end
      8: e.r = a << (b % DW);
      9: e.r = a >> (b % DW);
      default: e.r = '0;
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  task automatic drive_op(input int unsigned op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.ALUOperation = OW'(op);
    bus.A = a;
    bus.B = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.in_valid = 1'b1;
    bus.ALUOperation = 4'd3;
    bus.A = 32'd1;
    bus.B = 32'd1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.ALUResult !== 32'd0 || bus.Zero !== 1'b0 ||
          bus.Carry !== 1'b0 || bus.Overflow !== 1'b0 || bus.in_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL reset_values: got ov=%b res=%h z=%b c=%b o=%b rdy=%b, expected ov=0 res=0 z=0 c=0 o=0 rdy=1",
                 bus.out_valid, bus.ALUResult, bus.Zero, bus.Carry, bus.Overflow, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release_no_pulse: got out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_add_carry();
    exp_t e;
    e = model(3, 32'hFFFF_FFFF, 32'h1);
    drive_op(3, 32'hFFFF_FFFF, 32'h1);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.ALUResult !== e.r || bus.Zero !== e.z ||
        bus.Carry !== e.c || bus.Overflow !== e.o) begin
      n_errors++;
      $display("FAIL add_carry: got ov=%b res=%h z=%b c=%b o=%b, expected ov=1 res=%h z=%b c=%b o=%b",
               bus.out_valid, bus.ALUResult, bus.Zero, bus.Carry, bus.Overflow, e.r, e.z, e.c, e.o);
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.ALUResult !== e.r || bus.Carry !== e.c) begin
      n_errors++;
      $display("FAIL add_hold: got ov=%b res=%h c=%b, expected ov=0 res=%h c=%b",
               bus.out_valid, bus.ALUResult, bus.Carry, e.r, e.c);
    end
  endtask

  task automatic test_sub_overflow();
    exp_t e;
    e = model(4, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    drive_op(4, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.ALUResult !== e.r || bus.Zero !== e.z ||
        bus.Carry !== e.c || bus.Overflow !== e.o) begin
      n_errors++;
      $display("FAIL sub_overflow: got ov=%b res=%h z=%b c=%b o=%b, expected ov=1 res=%h z=%b c=%b o=%b",
               bus.out_valid, bus.ALUResult, bus.Zero, bus.Carry, bus.Overflow, e.r, e.z, e.c, e.o);
    end
  endtask

  task automatic test_back_to_back();
    exp_t exp_q[$];
    exp_t e;
    int unsigned ops[3];
    logic [DW-1:0] as[3];
    logic [DW-1:0] bs[3];
    ops[0] = 0; as[0] = DW'($urandom); bs[0] = DW'($urandom);
    ops[1] = 1; as[1] = DW'($urandom); bs[1] = DW'($urandom);
    ops[2] = 8; as[2] = 32'd1;         bs[2] = 32'd31;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.ALUResult !== e.r || bus.Zero !== e.z) begin
          n_errors++;
          $display("FAIL back_to_back_%0d: got ov=%b res=%h z=%b, expected ov=1 res=%h z=%b",
                   i - 1, bus.out_valid, bus.ALUResult, bus.Zero, e.r, e.z);
        end
      end
      if (i < 3) begin
        bus.in_valid = 1'b1;
        bus.ALUOperation = OW'(ops[i]);
        bus.A = as[i];
        bus.B = bs[i];
        exp_q.push_back(model(ops[i], as[i], bs[i]));
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.ALUResult !== 32'h8000_0000) begin
      n_errors++;
      $display("FAIL back_to_back_end: got ov=%b res=%h, expected ov=0 res=80000000",
               bus.out_valid, bus.ALUResult);
    end
  endtask

  task automatic test_multplus();
    int pulses = 0;
    int pulse_k = -1;
    int ready_err = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.ALUOperation = 4'd6;
    bus.A = 32'd3;
    bus.B = 32'd5;
    for (int k = 0; k < DW + 2; k++) begin
      @(negedge clk);
      if (bus.in_ready !== ((k >= DW - 1) ? 1'b1 : 1'b0)) ready_err++;
      if (bus.out_valid === 1'b1) begin
        pulses++;
        pulse_k = k;
        n_checks++;
        if (bus.ALUResult !== 32'd16 || bus.Zero !== 1'b0 || bus.Carry !== 1'b0 || bus.Overflow !== 1'b0) begin
          n_errors++;
          $display("FAIL multplus_result: got res=%h z=%b c=%b o=%b, expected res=00000010 z=0 c=0 o=0",
                   bus.ALUResult, bus.Zero, bus.Carry, bus.Overflow);
        end
      end
      // Junk requests while busy must be ignored; drop the request once in_ready returns.
      bus.in_valid = (k < DW - 1) ? 1'b1 : 1'b0;
      bus.ALUOperation = 4'd3;
      bus.A = DW'($urandom);
      bus.B = DW'($urandom);
    end
    n_checks++;
    if (ready_err != 0) begin
      n_errors++;
      $display("FAIL multplus_in_ready: got %0d cycles with wrong in_ready, expected 0", ready_err);
    end
    n_checks++;
    if (pulses != 1 || pulse_k != DW - 1) begin
      n_errors++;
      $display("FAIL multplus_latency: got %0d pulses, last at cycle %0d, expected 1 pulse at cycle %0d",
               pulses, pulse_k + 1, DW);
    end
    n_checks++;
    if (bus.ALUResult !== 32'd16) begin
      n_errors++;
      $display("FAIL multplus_hold: got res=%h expected 00000010", bus.ALUResult);
    end
  endtask

  task automatic test_mul_reset();
    int pulses = 0;
    exp_t e;
    drive_op(7, 32'h0001_0000, 32'h0001_0000);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) pulses++;
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.ALUResult !== 32'd0 || bus.Zero !== 1'b0) begin
      n_errors++;
      $display("FAIL mul_reset_values: got ov=%b rdy=%b res=%h z=%b, expected ov=0 rdy=1 res=0 z=0",
               bus.out_valid, bus.in_ready, bus.ALUResult, bus.Zero);
    end
    for (int k = 0; k < DW + 4; k++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_errors++;
      $display("FAIL mul_reset_abort: got %0d out_valid pulses, expected 0", pulses);
    end
    e = model(3, 32'd2, 32'd2);
    drive_op(3, 32'd2, 32'd2);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.ALUResult !== e.r) begin
      n_errors++;
      $display("FAIL add_after_reset: got ov=%b res=%h, expected ov=1 res=%h",
               bus.out_valid, bus.ALUResult, e.r);
    end
  endtask

  task automatic test_random();
    exp_t e;
    int unsigned op;
    logic [DW-1:0] a, b;
    int lat, want_lat;
    for (int n = 0; n < 200; n++) begin
      op = (n % 8 == 7) ? $urandom_range(6, 7) : $urandom_range(0, 15);
      case ($urandom_range(0, 5))
        0: a = 32'hFFFF_FFFF;
        1: a = 32'h8000_0000;
        2: a = 32'h7FFF_FFFF;
        default: a = DW'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'hFFFF_FFFF;
        1: b = 32'h0;
        2: b = a;
        default: b = DW'($urandom);
      endcase
      e = model(op, a, b);
      want_lat = (op == 6 || op == 7) ? DW : 1;
      drive_op(op, a, b);
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < DW + 4) begin
        @(negedge clk);
        lat++;
      end
      n_checks++;
      if (bus.out_valid !== 1'b1 || lat != want_lat || bus.ALUResult !== e.r || bus.Zero !== e.z ||
          bus.Carry !== e.c || bus.Overflow !== e.o) begin
        n_errors++;
        $display("FAIL random_op%0d a=%h b=%h: got ov=%b lat=%0d res=%h z=%b c=%b o=%b, expected ov=1 lat=%0d res=%h z=%b c=%b o=%b",
                 op, a, b, bus.out_valid, lat, bus.ALUResult, bus.Zero, bus.Carry, bus.Overflow,
                 want_lat, e.r, e.z, e.c, e.o);
      end
    end
  endtask

  // Main sequence of scenarios followed by the summary.
  initial begin
    bus.in_valid = 1'b0;
    bus.ALUOperation = 4'd0;
    bus.A = 32'd0;
    bus.B = 32'd0;
    test_reset();
    test_add_carry();
    test_sub_overflow();
    test_back_to_back();
    test_multplus();
    test_mul_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end
endmodule
